instr_queue: RTL and testbench

- Instruction FIFO directly downstream of the fetch control stage.
- Captures each returned {pc, instr} pair from the instruction-memory path and presents them in order to decode/dispatch with a valid/ready handshake.
- Produces the `instr_full` back-pressure signal consumed by fetch.
- On a branch flush, discards all queued entries and drops the one stale imem response still in flight.

---
 rtl/instr_queue.sv | 89 ++++++++
 tb/tb_instr_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction FIFO between fetch and decode: buffers {pc, instr} pairs and drops the stale in-flight imem response after a flush.
// Optional same-cycle enq->deq bypass on an empty queue when INSTR_QUEUE_BYPASS_EN is defined.
module instr_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             imem_busy,
    input  logic             enq_valid,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_instr,
    output logic             instr_full,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_instr,
    output logic [PTR_W:0]   count
);

    // state | meaning
    // RUN   | normal operation, pushes accepted
    // DRAIN | discard the next imem response (issued before the flush)
    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t           state, state_nxt;
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             bypass;
    logic             push, pop;

    assign instr_full = (count == FULL_CNT);

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && (state == RUN) && !flush && enq_valid;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = ((count != '0) && !flush) || bypass;
    assign deq_pc    = bypass ? enq_pc    : mem[rd_ptr][63:32];
    assign deq_instr = bypass ? enq_instr : mem[rd_ptr][31:0];

    // A bypassed entry consumed in the same cycle never touches storage.
    assign push = enq_valid && !instr_full && (state == RUN) && !flush
                  && !(bypass && deq_ready);
    assign pop  = (count != '0) && !flush && deq_ready;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = imem_busy ? DRAIN : RUN;
        end else if (state == DRAIN && enq_valid) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enq_pc, enq_instr};
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed test of instr_queue: ordering, full/wrap, simultaneous push/pop, flush, drain and bypass latency.
module tb_instr_queue;

`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, imem_busy, enq_valid, deq_ready;
    logic [31:0] enq_pc, enq_instr, deq_pc, deq_instr;
    logic        instr_full, deq_valid;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];

    instr_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .imem_busy(imem_busy),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .instr_full(instr_full), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [31:0] pc);
        enq_valid = v;
        enq_pc    = pc;
        enq_instr = instr_of(pc);
    endtask

    task automatic push(input logic [31:0] pc);
        drive_enq(1'b1, pc);
        cyc();
        enq_valid = 1'b0;
    endtask

    // Pop one entry, checking the head against the expected value first.
    task automatic pop_check(input string tag, input logic [31:0] pc);
        deq_ready = 1'b1;
        #1;
        check({tag, "_valid"}, 32'(deq_valid), 32'd1);
        check({tag, "_pc"}, deq_pc, pc);
        check({tag, "_instr"}, deq_instr, instr_of(pc));
        cyc();
        deq_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; imem_busy = 1'b0; deq_ready = 1'b0;
        drive_enq(1'b0, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(instr_full), 32'd0);
        check("rst_valid", 32'(deq_valid), 32'd0);

        // 1: ordering
        push(32'h1000); push(32'h1004);
        check("t1_latency_valid", 32'(deq_valid), 32'd1);
        push(32'h1008);
        #1;
        check("t1_count3", 32'(count), 32'd3);
        check("t1_head", deq_pc, 32'h1000);
        for (int i = 0; i < 3; i++) pop_check("t1_pop", 32'h1000 + 32'(4*i));
        #1;
        check("t1_count0", 32'(count), 32'd0);
        check("t1_valid0", 32'(deq_valid), 32'd0);

        // 2: full, ignored push, wrap
        for (int i = 0; i < 8; i++) begin
            check("t2_not_full", 32'(instr_full), 32'd0);
            push(32'h2000 + 32'(4*i));
            exp_q.push_back(32'h2000 + 32'(4*i));
        end
        check("t2_full", 32'(instr_full), 32'd1);
        check("t2_count8", 32'(count), 32'd8);
        push(32'h2020);
        check("t2_ovf_count", 32'(count), 32'd8);
        check("t2_ovf_head", deq_pc, 32'h2000);
        pop_check("t2_pop", exp_q.pop_front());
        check("t2_full_clr", 32'(instr_full), 32'd0);
        push(32'h2024);
        exp_q.push_back(32'h2024);
        check("t2_refill", 32'(count), 32'd8);
        pop_check("t2_pop", exp_q.pop_front());
        for (int i = 0; i < 16; i++) begin
            drive_enq(1'b1, 32'h2100 + 32'(4*i));
            exp_q.push_back(32'h2100 + 32'(4*i));
            pop_check("t2_wrap", exp_q.pop_front());
            enq_valid = 1'b0;
            check("t2_wrap_count", 32'(count), 32'd7);
        end
        while (exp_q.size() > 0) pop_check("t2_drain", exp_q.pop_front());
        check("t2_empty", 32'(count), 32'd0);

        // 3: simultaneous push/pop at count 4
        for (int i = 0; i < 4; i++) push(32'h3100 + 32'(4*i));
        drive_enq(1'b1, 32'h3000);
        pop_check("t3_sim", 32'h3100);
        enq_valid = 1'b0;
        check("t3_count4", 32'(count), 32'd4);
        pop_check("t3_p1", 32'h3104);
        pop_check("t3_p2", 32'h3108);
        pop_check("t3_p3", 32'h310C);
        pop_check("t3_p4", 32'h3000);
        check("t3_empty", 32'(count), 32'd0);

        // 4: flush without outstanding imem
        for (int i = 0; i < 5; i++) push(32'h4100 + 32'(4*i));
        flush = 1'b1; deq_ready = 1'b1;
        drive_enq(1'b1, 32'hDEAD_0000);
        #1;
        check("t4_flush_valid", 32'(deq_valid), 32'd0);
        cyc();
        flush = 1'b0; deq_ready = 1'b0; enq_valid = 1'b0;
        check("t4_count0", 32'(count), 32'd0);
        check("t4_valid0", 32'(deq_valid), 32'd0);
        push(32'h4000);
        check("t4_count1", 32'(count), 32'd1);
        pop_check("t4_pop", 32'h4000);

        // 5: flush with outstanding imem, stale response dropped
        push(32'h5100);
        flush = 1'b1; imem_busy = 1'b1;
        cyc();
        flush = 1'b0; imem_busy = 1'b0;
        check("t5_count0", 32'(count), 32'd0);
        push(32'h5000);
        check("t5_stale_count", 32'(count), 32'd0);
        check("t5_stale_valid", 32'(deq_valid), 32'd0);
        push(32'h6000);
        check("t5_count1", 32'(count), 32'd1);
        pop_check("t5_pop", 32'h6000);

        // 6: bypass latency
        drive_enq(1'b1, 32'h7000);
        deq_ready = 1'b1;
        #1;
        check("t6_same_valid", 32'(deq_valid), BYP ? 32'd1 : 32'd0);
        check("t6_same_pc", BYP ? deq_pc : 32'h7000, 32'h7000);
        cyc();
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("t6_count", 32'(count), BYP ? 32'd0 : 32'd1);
        check("t6_next_valid", 32'(deq_valid), BYP ? 32'd0 : 32'd1);
        if (!BYP) pop_check("t6_pop", 32'h7000);

        // rst overrides flush mid-operation
        push(32'h8000); push(32'h8004);
        rst = 1'b1; flush = 1'b1; imem_busy = 1'b1;
        cyc();
        rst = 1'b0; flush = 1'b0; imem_busy = 1'b0;
        check("rst_mid_count", 32'(count), 32'd0);
        push(32'h8100);
        check("rst_mid_run", 32'(count), 32'd1);
        pop_check("rst_mid_pop", 32'h8100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
